// File: rtl/usb_led_cmd_rx.sv
// usb_led_cmd_rx: parses "#RGB"+CR/LF colour commands from the USB UART byte
// stream into three 4-bit duty registers and drives a free-running 4-bit PWM
// onto the RGB LED outputs. Malformed or stalled lines are counted and dropped.
module usb_led_cmd_rx #(
    parameter int PRESCALE = 12,
    parameter int TIMEOUT  = 48000000
) (
    input  logic       clk_48mhz,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b,
    output logic       cmd_strobe,
    output logic       cmd_error,
    output logic [7:0] err_count
);

    typedef enum logic [2:0] {IDLE, D0, D1, D2, TERM, APPLY, ERR, DISCARD} state_t;

    // Idle count at which the next empty cycle reaches TIMEOUT-1.
    localparam logic [25:0] IDLE_LAST = 26'(TIMEOUT - 2);
    localparam logic [7:0]  PRE_LAST  = 8'(PRESCALE - 1);

    state_t      state, state_nxt;
    logic [3:0]  shadow_r, shadow_g, shadow_b;
    logic [3:0]  duty_r, duty_g, duty_b;
    logic [25:0] idle_cnt;
    logic        err_soft;      // pending ERR goes straight back to IDLE
    logic [7:0]  presc;
    logic [3:0]  pwm_cnt;

    logic        accept, is_hex, is_term, in_line, timeout_hit;
    logic [3:0]  hex_val;

    assign rx_ready    = reset && (state != APPLY) && (state != ERR);
    assign accept      = rx_valid && rx_ready;
    assign is_term     = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    assign in_line     = (state == D0) || (state == D1) || (state == D2) || (state == TERM);
    assign timeout_hit = in_line && !accept && (idle_cnt == IDLE_LAST);

    // Hex digit decode; letters map via low nibble + 9 ('a'/'A' low nibble = 1).
    always_comb begin
        is_hex  = 1'b0;
        hex_val = 4'd0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            is_hex  = 1'b1;
            hex_val = rx_data[3:0];
        end else if ((rx_data >= 8'h61 && rx_data <= 8'h66) ||
                     (rx_data >= 8'h41 && rx_data <= 8'h46)) begin
            is_hex  = 1'b1;
            hex_val = rx_data[3:0] + 4'd9;
        end
    end

    // Next-state logic for the line parser.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && rx_data == 8'h23) state_nxt = D0;
            D0:      if (accept) state_nxt = is_hex ? D1 : ERR;
            D1:      if (accept) state_nxt = is_hex ? D2 : ERR;
            D2:      if (accept) state_nxt = is_hex ? TERM : ERR;
            TERM:    if (accept) state_nxt = is_term ? APPLY : ERR;
            APPLY:   state_nxt = IDLE;
            ERR:     state_nxt = err_soft ? IDLE : DISCARD;
            DISCARD: if (accept && is_term) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (timeout_hit) state_nxt = ERR;
    end

    // Parser state, pulses, error counter, idle timer, shadows and duties.
    always_ff @(posedge clk_48mhz) begin
        if (!reset) begin
            state      <= IDLE;
            cmd_strobe <= 1'b0;
            cmd_error  <= 1'b0;
            err_count  <= 8'd0;
            err_soft   <= 1'b0;
            idle_cnt   <= 26'd0;
            shadow_r   <= 4'd0;
            shadow_g   <= 4'd0;
            shadow_b   <= 4'd0;
            duty_r     <= 4'd0;
            duty_g     <= 4'd0;
            duty_b     <= 4'd0;
        end else begin
            state      <= state_nxt;
            cmd_strobe <= (state_nxt == APPLY);
            cmd_error  <= (state_nxt == ERR);
            if (state_nxt == ERR) begin
                err_soft <= timeout_hit || is_term;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
            if (!in_line || accept) idle_cnt <= 26'd0;
            else                    idle_cnt <= idle_cnt + 26'd1;
            if (accept && is_hex) begin
                if (state == D0) shadow_r <= hex_val;
                if (state == D1) shadow_g <= hex_val;
                if (state == D2) shadow_b <= hex_val;
            end
            if (accept && state == TERM && is_term) begin
                duty_r <= shadow_r;
                duty_g <= shadow_g;
                duty_b <= shadow_b;
            end
        end
    end

    // Free-running prescaled PWM; duty 15 forced fully on.
    always_ff @(posedge clk_48mhz) begin
        if (!reset) begin
            presc   <= 8'd0;
            pwm_cnt <= 4'd0;
            led_r   <= 1'b0;
            led_g   <= 1'b0;
            led_b   <= 1'b0;
        end else begin
            if (presc == PRE_LAST) begin
                presc   <= 8'd0;
                pwm_cnt <= pwm_cnt + 4'd1;
            end else begin
                presc <= presc + 8'd1;
            end
            led_r <= (duty_r == 4'hF) || (pwm_cnt < duty_r);
            led_g <= (duty_g == 4'hF) || (pwm_cnt < duty_g);
            led_b <= (duty_b == 4'hF) || (pwm_cnt < duty_b);
        end
    end

endmodule

// File: tb/tb_usb_led_cmd_rx.sv
// tb_usb_led_cmd_rx: directed bench for the colour command decoder.
module tb_usb_led_cmd_rx;

    logic       clk_48mhz = 1'b0;
    logic       reset     = 1'b0;
    logic [7:0] rx_data   = 8'd0;
    logic       rx_valid  = 1'b0;
    logic       rx_ready, led_r, led_g, led_b, cmd_strobe, cmd_error;
    logic [7:0] err_count;

    int n_cmp = 0, n_bad = 0;
    int n_strobe = 0, n_err = 0, n_acc = 0, n_both = 0;
    int cr, cg, cb, s0, e0, a0;

    usb_led_cmd_rx #(.PRESCALE(12), .TIMEOUT(100)) dut (
        .clk_48mhz(clk_48mhz), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .led_r(led_r), .led_g(led_g), .led_b(led_b),
        .cmd_strobe(cmd_strobe), .cmd_error(cmd_error), .err_count(err_count)
    );

    always #5 clk_48mhz = ~clk_48mhz;

    // Pulse counters and the strobe/error exclusivity watch.
    always @(negedge clk_48mhz) begin
        if (cmd_strobe) n_strobe++;
        if (cmd_error) n_err++;
        if (cmd_strobe && cmd_error) n_both++;
    end

    // Count transfers that the coming rising edge will perform.
    always @(negedge clk_48mhz) begin
        #3;
        if (rx_valid && rx_ready) n_acc++;
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Present one byte and return right after the edge that transfers it.
    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk_48mhz); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            @(negedge clk_48mhz);
            n++;
        end
        if (n >= 50) chk("send_stall", n, 0);
        @(posedge clk_48mhz);
    endtask

    task automatic gap(input int g);
        if (g > 0) begin
            @(negedge clk_48mhz); #1;
            rx_valid = 1'b0;
            repeat (g - 1) @(negedge clk_48mhz);
        end
    endtask

    task automatic send_str(input string s, input int maxgap);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
            if (maxgap > 0 && i < s.len() - 1) gap($urandom_range(maxgap, 0));
        end
    endtask

    task automatic stop();
        @(negedge clk_48mhz); #1;
        rx_valid = 1'b0;
    endtask

    // High-cycle counts of each LED over one full PWM period.
    task automatic measure(output int r, output int g, output int b);
        r = 0; g = 0; b = 0;
        repeat (4) @(negedge clk_48mhz);
        repeat (192) begin
            @(negedge clk_48mhz);
            r += int'(led_r); g += int'(led_g); b += int'(led_b);
        end
    endtask

    task automatic chk_leds(input string tag, input int r, input int g, input int b);
        measure(cr, cg, cb);
        chk({tag, "_r"}, cr, r);
        chk({tag, "_g"}, cg, g);
        chk({tag, "_b"}, cb, b);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (4) @(negedge clk_48mhz);
        chk("rst_ready", int'(rx_ready), 0);
        chk("rst_led_r", int'(led_r), 0);
        chk("rst_errcnt", int'(err_count), 0);
        chk("rst_strobe", int'(cmd_strobe), 0);
        #1 reset = 1'b1;

        // Back-to-back #f80\r
        s0 = n_strobe;
        send_str("#f80\r", 0);
        @(negedge clk_48mhz);
        chk("t1_stall_ready", int'(rx_ready), 0);
        chk("t1_strobe_hi", int'(cmd_strobe), 1);
        #1 rx_valid = 1'b0;
        @(negedge clk_48mhz);
        chk("t1_ready_back", int'(rx_ready), 1);
        chk("t1_strobe_lo", int'(cmd_strobe), 0);
        chk("t1_nstrobe", n_strobe - s0, 1);
        chk_leds("t1_led", 192, 96, 0);

        // Garbage, good line, bad line, good line
        s0 = n_strobe;
        send_str("xyz#A5c\n", 0);
        stop();
        chk_leds("t2a_led", 120, 60, 144);
        chk("t2a_nstrobe", n_strobe - s0, 1);
        e0 = n_err;
        send_str("#1g", 0);
        @(negedge clk_48mhz);
        chk("t2_err_hi", int'(cmd_error), 1);
        chk("t2_err_ready", int'(rx_ready), 0);
        chk("t2_errcnt", int'(err_count), 1);
        #1 rx_valid = 1'b0;
        s0 = n_strobe;
        send_str("2\r", 0);
        stop();
        repeat (2) @(negedge clk_48mhz);
        chk("t2_discard_nstrobe", n_strobe - s0, 0);
        chk("t2_discard_nerr", n_err - e0, 1);
        chk_leds("t2b_led", 120, 60, 144);
        send_str("#003\n", 0);
        stop();
        chk_leds("t2c_led", 0, 0, 36);

        // Timeout mid-line
        send_str("#12", 0);
        @(negedge clk_48mhz); #1;
        rx_valid = 1'b0;
        repeat (98) @(negedge clk_48mhz);
        chk("t3_err_early", int'(cmd_error), 0);
        @(negedge clk_48mhz);
        chk("t3_err_at99", int'(cmd_error), 1);
        chk("t3_errcnt", int'(err_count), 2);
        send_str("#fff\r", 0);
        stop();
        chk_leds("t3_led", 192, 192, 192);

        // Error counter saturation
        e0 = n_err;
        for (int i = 0; i < 300; i++) send_str("#\r", 0);
        stop();
        repeat (2) @(negedge clk_48mhz);
        chk("t4_nerr", n_err - e0, 300);
        chk("t4_errcnt_sat", int'(err_count), 255);
        s0 = n_strobe;
        send_str("#abc\r", 0);
        stop();
        chk_leds("t4_led", 120, 132, 144);
        chk("t4_nstrobe", n_strobe - s0, 1);

        // Reset mid-line
        send_str("#4", 0);
        @(negedge clk_48mhz); #1;
        rx_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk_48mhz); #1;
        reset = 1'b1;
        chk("t5_errcnt_clr", int'(err_count), 0);
        s0 = n_strobe; e0 = n_err;
        send_str("56\r", 0);
        stop();
        repeat (2) @(negedge clk_48mhz);
        chk("t5_nstrobe", n_strobe - s0, 0);
        chk("t5_nerr", n_err - e0, 0);
        send_str("#777\r", 0);
        stop();
        chk_leds("t5_led", 84, 84, 84);
        chk("t5_errcnt", int'(err_count), 0);

        // Random source gaps
        s0 = n_strobe; a0 = n_acc;
        send_str("#9aB\r", 5);
        stop();
        repeat (2) @(negedge clk_48mhz);
        chk("t6_nacc", n_acc - a0, 5);
        chk("t6_nstrobe", n_strobe - s0, 1);
        chk_leds("t6_led", 108, 120, 132);
        chk("both_pulses", n_both, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
